inst_encoder: RTL and testbench
===============================

# inst_encoder

- Assembles 32-bit RISC-V instruction words from decoded fields: opcode, registers, funct bits and a 32-bit immediate.
- Scatters the immediate into the bit positions our immediate generator reads back. Every legal immediate therefore round-trips exactly through `imm_gen` for the same `IMM_SEL`.
- Sits on the program-loader path ahead of instruction memory. It buffers words behind a valid/ready handshake, stamps each with a byte address, and flags immediates the format cannot represent.

## Interface
- INST_WIDTH, `INST_WIDTH (32), instruction word width
- IMM_SEL_WIDTH, `IMM_SEL_WIDTH, format select width
- REG_WIDTH, `REG_WIDTH (32), immediate input width
- ADDR_WIDTH, 12, byte-address width of out_addr

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- addr_clr  in  1  synchronous: next accepted word gets address 0; clears err_sticky
- in_valid  in  1  field set valid
- in_ready  out  1  encoder can accept
- in_sel  in  IMM_SEL_WIDTH  format: `IMM_SEL_I/S/B/J, any other code = R
- in_opcode  in  7  opcode
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3; in_funct7  in  7 (R only)
- in_imm  in  REG_WIDTH  immediate, two's complement
- out_valid  out  1  word valid
- out_ready  in  1  consumer accepts
- out_inst  out  INST_WIDTH  encoded word
- out_addr  out  ADDR_WIDTH  byte address of out_inst
- out_err  out  1  immediate of this word out of range or misaligned
- err_sticky  out  1  any out_err word accepted since reset/addr_clr

## Operation
Encoding is `{msb..lsb}`:
- **I:** `{imm[11:0], rs1, f3, rd, op}`. Legal range is -2048..2047.
- **S:** `{imm[11:5], rs2, rs1, f3, imm[4:0], op}`. Legal range is -2048..2047.
- **B:** `{imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}`. Legal range is -4096..4094; imm[0] must be 0.
- **J:** `{imm[12:1], rs1, f3, rd, op}`. Legal range is -4096..4094; imm[0] must be 0. This matches the team J layout decoded by `imm_gen`.
- **R:** `{f7, rs2, rs1, f3, rd, op}`. No immediate check; out_err=0.

Behaviour:
- **Illegal immediate:** the word is still emitted, truncated to the listed bits, with out_err=1.
- **Buffer:** 2-entry FIFO holding {inst, addr, err}.
  - in_ready = !full, registered.
  - Encoding and range check are combinational into the FIFO write.
- **Address counter:**
  - Resets to 0.
  - Is assigned at FIFO write and advances by 4 on each accepted input.
  - Wraps modulo 2^ADDR_WIDTH with no flag.
- **addr_clr:**
  - With a simultaneous input accept, that word gets address 0 and the counter becomes 4.
  - Words already buffered keep their addresses.
- **err_sticky:**
  - Sets on an output handshake with out_err=1.
  - If addr_clr coincides with such a handshake, set wins.
- **FIFO states:** EMPTY → ONE → FULL.
  - Write only: moves up one state.
  - Read only: moves down one state.
  - Simultaneous write and read in ONE: stays ONE.
  - FULL blocks writes, so write and read cannot both happen in FULL.

## Timing
- Reset values: in_ready=1, out_valid=0, out_inst=0, out_addr=0, out_err=0, err_sticky=0, counter=0, FIFO=EMPTY.
- Latency: a word accepted on edge N is presented with out_valid=1 after edge N.
- Throughput: 1 word/cycle while out_ready=1.
- out_inst, out_addr and out_err stay stable while out_valid && !out_ready.
- in_ready falls the cycle after FIFO reaches FULL. in_ready never depends combinationally on out_ready.
- Reset asserted mid-transfer: FIFO is flushed, words in flight are lost, and all outputs return to their reset values immediately (asynchronous).

## Structure
- `IMM_SEL_*` codes, the widths, and new opcode constants (`OPC_OP_IMM`, `OPC_STORE`, `OPC_BRANCH`) live in risc_v_defines.vh.
- One sub-module, `inst_enc_fifo`: a 2-entry synchronous FIFO parameterised by data width.
- Encoding, range check and the address counter stay in `inst_encoder`.

## Test plan
- **I-type:** I, op=0x13, rd=1, rs1=0, f3=0, imm=5 → out_inst=0x00500093, out_addr=0, out_err=0.
- **S-type:** S, op=0x23, rs1=1, rs2=2, f3=2, imm=8 → 0x0020A423, out_addr=4.
- **B-type:** B, op=0x63, rs1=rs2=0, f3=0, imm=-4 → 0xFE000EE3. Feeding it to `imm_gen` with `IMM_SEL_B` returns 0xFFFFFFFC.
- **Range/misalignment:**
  - I imm=2048 → out_err=1, imm field 0x800.
  - B imm=3 → out_err=1.
  - err_sticky=1 after the handshake; then addr_clr → err_sticky=0 and next out_addr=0.
- **Backpressure:** out_ready=0 while sending 3 words → in_ready=0 after the 2nd; release → 3 words emitted in order with addresses 0, 4, 8; no loss or duplication.
- **Reset and wrap:** assert rst_n=0 with FULL FIFO → out_valid=0 and in_ready=1 immediately. Separately, with ADDR_WIDTH=4, the 5th word has out_addr=0.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// Shared constants for the instruction encoder: widths, immediate-format select
// codes, opcodes and the buffer state encoding.
package inst_encoder_pkg;

  localparam int unsigned RV_INST_WIDTH    = 32;
  localparam int unsigned RV_IMM_SEL_WIDTH = 3;
  localparam int unsigned RV_REG_WIDTH     = 32;

  // Any select code not listed here encodes as R-type.
  localparam logic [2:0] IMM_SEL_I = 3'd1;
  localparam logic [2:0] IMM_SEL_S = 3'd2;
  localparam logic [2:0] IMM_SEL_B = 3'd3;
  localparam logic [2:0] IMM_SEL_J = 3'd4;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/inst_enc_fifo.sv
// Two-entry synchronous FIFO; entry0 is always the head, so the read data
// comes straight from a flop and holds steady under backpressure.
module inst_enc_fifo
  import inst_encoder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 45
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data
);

  fifo_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
  logic [DATA_WIDTH-1:0] entry1_q, entry1_d;
  logic                  wr_en, rd_en;

  assign wr_en = wr_valid && (state_q != FIFO_FULL);
  assign rd_en = rd_ready && (state_q != FIFO_EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FIFO_EMPTY;
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      state_q  <= state_d;
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    unique case (state_q)
      FIFO_EMPTY: begin
        if (wr_en) begin
          state_d  = FIFO_ONE;
          entry0_d = wr_data;
        end
      end
      FIFO_ONE: begin
        if (wr_en && rd_en) begin
          entry0_d = wr_data;
        end else if (wr_en) begin
          state_d  = FIFO_FULL;
          entry1_d = wr_data;
        end else if (rd_en) begin
          state_d  = FIFO_EMPTY;
        end
      end
      FIFO_FULL: begin
        if (rd_en) begin
          state_d  = FIFO_ONE;
          entry0_d = entry1_q;
        end
      end
      default: state_d = FIFO_EMPTY;
    endcase
  end

  // wr_ready decodes only registered state, never rd_ready.
  always_comb begin
    wr_ready = (state_q != FIFO_FULL);
    rd_valid = (state_q != FIFO_EMPTY);
    rd_data  = entry0_q;
  end

endmodule

// File: rtl/inst_encoder.sv
// Builds RISC-V instruction words from decoded fields, flags unrepresentable
// immediates, stamps a byte address and buffers the result for the loader.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned INST_WIDTH    = RV_INST_WIDTH,
  parameter int unsigned IMM_SEL_WIDTH = RV_IMM_SEL_WIDTH,
  parameter int unsigned REG_WIDTH     = RV_REG_WIDTH,
  parameter int unsigned ADDR_WIDTH    = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     addr_clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IMM_SEL_WIDTH-1:0] in_sel,
  input  logic [6:0]               in_opcode,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [REG_WIDTH-1:0]     in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INST_WIDTH-1:0]    out_inst,
  output logic [ADDR_WIDTH-1:0]    out_addr,
  output logic                     out_err,
  output logic                     err_sticky
);

  localparam int unsigned DATA_WIDTH = INST_WIDTH + ADDR_WIDTH + 1;

  localparam logic signed [REG_WIDTH-1:0] SHORT_MIN = REG_WIDTH'(-2048);
  localparam logic signed [REG_WIDTH-1:0] SHORT_MAX = REG_WIDTH'(2047);
  localparam logic signed [REG_WIDTH-1:0] LONG_MIN  = REG_WIDTH'(-4096);
  localparam logic signed [REG_WIDTH-1:0] LONG_MAX  = REG_WIDTH'(4094);

  logic signed [REG_WIDTH-1:0] imm_s;
  logic                        short_ok, long_ok;
  logic [31:0]                 word;
  logic                        imm_err;
  logic                        accept, out_hs;
  logic [ADDR_WIDTH-1:0]       wr_addr;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic                        err_sticky_q, err_sticky_d;
  logic [DATA_WIDTH-1:0]       wr_data, rd_data;

  assign imm_s    = $signed(in_imm);
  assign short_ok = (imm_s >= SHORT_MIN) && (imm_s <= SHORT_MAX);
  assign long_ok  = (imm_s >= LONG_MIN) && (imm_s <= LONG_MAX) && !in_imm[0];

  always_comb begin
    word    = '0;
    imm_err = 1'b0;
    case (in_sel)
      IMM_SEL_WIDTH'(IMM_SEL_I): begin
        word    = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        imm_err = !short_ok;
      end
      IMM_SEL_WIDTH'(IMM_SEL_S): begin
        word    = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        imm_err = !short_ok;
      end
      IMM_SEL_WIDTH'(IMM_SEL_B): begin
        word    = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], in_opcode};
        imm_err = !long_ok;
      end
      IMM_SEL_WIDTH'(IMM_SEL_J): begin
        word    = {in_imm[12:1], in_rs1, in_funct3, in_rd, in_opcode};
        imm_err = !long_ok;
      end
      default: begin
        word    = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        imm_err = 1'b0;
      end
    endcase
  end

  assign accept  = in_valid && in_ready;
  assign out_hs  = out_valid && out_ready;
  assign wr_addr = addr_clr ? '0 : addr_q;
  assign wr_data = {imm_err, wr_addr, INST_WIDTH'(word)};

  // A clear alongside an accept restarts numbering at the accepted word.
  always_comb begin
    addr_d = addr_q;
    if (accept) begin
      addr_d = wr_addr + ADDR_WIDTH'(4);
    end else if (addr_clr) begin
      addr_d = '0;
    end
  end

  always_comb begin
    err_sticky_d = err_sticky_q;
    if (addr_clr) begin
      err_sticky_d = 1'b0;
    end
    if (out_hs && out_err) begin
      err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  inst_enc_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (wr_data),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (rd_data)
  );

  assign {out_err, out_addr, out_inst} = rd_data;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: expected words are queued on input accept
// and compared when the encoder hands them out.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        addr_clr, in_valid, in_ready, out_valid, out_ready, out_err, err_sticky;
  logic [2:0]  in_sel;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm, out_inst;
  logic [11:0] out_addr;

  logic        w_addr_clr, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_err, w_err_sticky;
  logic [31:0] w_out_inst;
  logic [3:0]  w_out_addr;

  typedef struct {
    logic [31:0] inst;
    logic [11:0] addr;
    logic        err;
    logic        rt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [11:0] exp_addr = '0;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .addr_clr(addr_clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
    .err_sticky(err_sticky)
  );

  inst_encoder #(.ADDR_WIDTH(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .addr_clr(w_addr_clr), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_sel(IMM_SEL_I), .in_opcode(OPC_OP_IMM), .in_rd(5'd1), .in_rs1(5'd0), .in_rs2(5'd0),
    .in_funct3(3'd0), .in_funct7(7'd0), .in_imm(32'd7), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_inst(w_out_inst), .out_addr(w_out_addr), .out_err(w_out_err),
    .err_sticky(w_err_sticky)
  );

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    logic [31:0] r;
    r = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_word observed=%0h expected=none", out_inst);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_inst", out_inst, e.inst);
        chk("out_addr", 32'(out_addr), 32'(e.addr));
        chk("out_err", 32'(out_err), 32'(e.err));
        if (e.rt) chk("imm_b_roundtrip", imm_b(out_inst), 32'hFFFF_FFFC);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic clr,
                      input logic [31:0] einst, input logic eerr, input logic rt);
    exp_t        e;
    logic [11:0] a;
    bit          done;
    done = 1'b0;
    in_sel = sel; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; addr_clr = clr; in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        a = clr ? 12'd0 : exp_addr;
        exp_addr = a + 12'd4;
        e.inst = einst; e.addr = a; e.err = eerr; e.rt = rt;
        sb.push_back(e);
        done = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    addr_clr = 1'b0;
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted");
    end
  endtask

  initial begin
    rst_n = 1'b0; addr_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sel = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    w_addr_clr = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Encodings, boundaries and illegal immediates, streamed back to back.
    out_ready = 1'b1;
    send(IMM_SEL_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h0050_0093, 1'b0, 1'b0);
    send(IMM_SEL_S, OPC_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 32'h0020_A423, 1'b0, 1'b0);
    send(IMM_SEL_B, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0, 32'hFE00_0EE3, 1'b0, 1'b1);
    send(IMM_SEL_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'h8000_0093, 1'b1, 1'b0);
    send(IMM_SEL_B, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'h0000_0163, 1'b1, 1'b0);
    send(IMM_SEL_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'h4000_00EF, 1'b0, 1'b0);
    send(3'd0, OPC_OP, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd99999, 1'b0, 32'h4031_00B3, 1'b0, 1'b0);
    send(IMM_SEL_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 1'b0, 32'h8000_00EF, 1'b1, 1'b0);
    send(IMM_SEL_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 1'b0, 32'h8000_0093, 1'b0, 1'b0);
    send(IMM_SEL_B, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094, 1'b0, 32'h7E00_0FE3, 1'b0, 1'b0);
    send(IMM_SEL_S, OPC_STORE, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F7FF, 1'b0, 32'h7E00_0FA3, 1'b1, 1'b0);
    idle(4);
    chk("sticky_set", 32'(err_sticky), 32'd1);

    addr_clr = 1'b1;
    idle(1);
    addr_clr = 1'b0;
    exp_addr = '0;
    chk("sticky_cleared", 32'(err_sticky), 32'd0);
    send(IMM_SEL_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'h0050_0093, 1'b0, 1'b0);
    send(IMM_SEL_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093, 1'b0, 1'b0);
    send(IMM_SEL_S, OPC_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 32'h0020_A423, 1'b0, 1'b0);
    idle(3);

    // Backpressure: two words fill the buffer, third waits for release.
    out_ready = 1'b0;
    send(IMM_SEL_I, OPC_OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'h0010_0113, 1'b0, 1'b0);
    send(IMM_SEL_I, OPC_OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 32'h0020_0193, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    idle(2);
    chk("hold_out_valid", 32'(out_valid), 32'd1);
    chk("hold_out_inst", out_inst, 32'h0010_0113);
    chk("hold_out_addr", 32'(out_addr), 32'd8);
    out_ready = 1'b1;
    send(IMM_SEL_I, OPC_OP_IMM, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'h0030_0213, 1'b0, 1'b0);
    idle(4);
    chk("drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset while the buffer is full.
    out_ready = 1'b0;
    send(IMM_SEL_I, OPC_OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'h0010_0113, 1'b0, 1'b0);
    send(IMM_SEL_I, OPC_OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 32'h0020_0193, 1'b0, 1'b0);
    chk("full2_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_inst", out_inst, 32'd0);
    chk("arst_out_addr", 32'(out_addr), 32'd0);
    sb.delete();
    exp_addr = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // addr_clr on the same edge as an erroring handshake: sticky still sets.
    send(IMM_SEL_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 1'b0, 32'h0000_0093, 1'b1, 1'b0);
    idle(1);
    out_ready = 1'b1;
    addr_clr = 1'b1;
    idle(1);
    addr_clr = 1'b0;
    exp_addr = '0;
    chk("sticky_set_wins", 32'(err_sticky), 32'd1);

    // 4-bit address counter wraps on the fifth word.
    w_in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      chk("wrap_out_valid", 32'(w_out_valid), 32'd1);
      chk("wrap_out_addr", 32'(w_out_addr), 32'((k * 4) % 16));
    end
    w_in_valid = 1'b0;
    idle(2);
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
